mem_wb_stage: RTL and testbench

Parametrised MEM/WB pipeline register for the pipelined CPU, successor to the fixed 32-bit MEM/WB latch. Adds a valid bit, stall (hold) and flush (bubble) control, asynchronous reset, and configurable data and register-address widths. Also produces the final write-back data and a qualified register-file write enable, so the register file and forwarding unit connect directly.

---
 rtl/cpu_pipe_pkg.sv | 17 +
 rtl/mem_wb_stage_if.sv | 46 ++++
 rtl/pipe_reg.sv | 29 ++
 rtl/mem_wb_stage.sv | 103 ++++++++++
 tb/tb_mem_wb_stage.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: default datapath widths and the WB control
// bundle carried by the MEM/WB register.
package cpu_pipe_pkg;

  localparam int DATA_W = 32;
  localparam int REG_AW = 5;

  // Control bits that travel with an instruction into the WB stage.
  typedef struct packed {
    logic valid;
    logic mem2r;
    logic regw;
  } wb_ctrl_t;

  localparam int WB_CTRL_W = $bits(wb_ctrl_t);

endpackage : cpu_pipe_pkg

// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side inputs, pipeline control and WB-side outputs.
// master = upstream pipeline control / MEM stage, slave = the MEM/WB register.
interface mem_wb_stage_if
  import cpu_pipe_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int AW = REG_AW
);

  // pipeline control
  logic          Stall;
  logic          Flush;

  // MEM side
  logic          Valid_MEM;
  logic          Mem2R_MEM;
  logic          RegW_MEM;
  logic [DW-1:0] dmDataOut;
  logic [DW-1:0] aluDataOut_MEM;
  logic [AW-1:0] MEM_rfWeSel;

  // WB side
  logic          Valid_WB;
  logic          Mem2R_WB;
  logic          RegW_WB;
  logic [DW-1:0] dmDataOut_WB;
  logic [DW-1:0] aluDataOut_WB;
  logic [AW-1:0] WB_rfWeSel;
  logic [DW-1:0] wbData_WB;
  logic          RegWe_WB;

  modport master (
    output Stall, Flush, Valid_MEM, Mem2R_MEM, RegW_MEM,
           dmDataOut, aluDataOut_MEM, MEM_rfWeSel,
    input  Valid_WB, Mem2R_WB, RegW_WB, dmDataOut_WB, aluDataOut_WB,
           WB_rfWeSel, wbData_WB, RegWe_WB
  );

  modport slave (
    input  Stall, Flush, Valid_MEM, Mem2R_MEM, RegW_MEM,
           dmDataOut, aluDataOut_MEM, MEM_rfWeSel,
    output Valid_WB, Mem2R_WB, RegW_WB, dmDataOut_WB, aluDataOut_WB,
           WB_rfWeSel, wbData_WB, RegWe_WB
  );

endinterface : mem_wb_stage_if

// File: rtl/pipe_reg.sv
// Generic pipeline register with asynchronous reset, synchronous clear and
// hold. Precedence at a clock edge: reset, then clear, then hold, else load.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         hold,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  // State register: reset wins, clear inserts zeros, hold keeps contents.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      q_reg <= '0;
    end else if (clear) begin
      q_reg <= '0;
    end else if (!hold) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule : pipe_reg

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid bit, stall/flush control and the final
// write-back mux plus qualified register-file write enable.
// Optional retire counter (RetireCnt port) enabled by MEMWB_RETIRE_CNT_EN.
module mem_wb_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DW           = DATA_W,
  parameter int AW           = REG_AW,
  parameter bit R0_HARDWIRED = 1'b1,
  parameter int CW           = 32
) (
  input  logic          Clk,
  input  logic          Rst,
  mem_wb_stage_if.slave bus
`ifdef MEMWB_RETIRE_CNT_EN
  ,
  output logic [CW-1:0] RetireCnt
`endif
);

  localparam int DATA_REG_W = 2 * DW + AW;

  // Reject nonsensical widths at elaboration time.
  if (DW < 1 || AW < 1 || CW < 1) begin : g_param_check
    $error("mem_wb_stage: DW, AW and CW must all be positive");
  end

  // ---------------------------------------------------------------------
  // Control bits: a flush clears them (bubble), a stall holds them.
  // ---------------------------------------------------------------------
  wb_ctrl_t ctrl_next;
  wb_ctrl_t ctrl_reg;

  assign ctrl_next.valid = bus.Valid_MEM;
  assign ctrl_next.mem2r = bus.Mem2R_MEM;
  assign ctrl_next.regw  = bus.RegW_MEM;

  pipe_reg #(.W(WB_CTRL_W)) u_ctrl_reg (
    .Clk   (Clk),
    .Rst   (Rst),
    .hold  (bus.Stall),
    .clear (bus.Flush),
    .d     (ctrl_next),
    .q     (ctrl_reg)
  );

  // ---------------------------------------------------------------------
  // Data and destination address: never cleared. A flushed slot is
  // invalid, so its data is don't-care and simply keeps the old contents.
  // ---------------------------------------------------------------------
  logic [DATA_REG_W-1:0] data_next;
  logic [DATA_REG_W-1:0] data_reg;

  assign data_next = {bus.dmDataOut, bus.aluDataOut_MEM, bus.MEM_rfWeSel};

  pipe_reg #(.W(DATA_REG_W)) u_data_reg (
    .Clk   (Clk),
    .Rst   (Rst),
    .hold  (bus.Stall | bus.Flush),
    .clear (1'b0),
    .d     (data_next),
    .q     (data_reg)
  );

  assign bus.Valid_WB      = ctrl_reg.valid;
  assign bus.Mem2R_WB      = ctrl_reg.mem2r;
  assign bus.RegW_WB       = ctrl_reg.regw;
  assign bus.dmDataOut_WB  = data_reg[DATA_REG_W-1 -: DW];
  assign bus.aluDataOut_WB = data_reg[AW +: DW];
  assign bus.WB_rfWeSel    = data_reg[AW-1:0];

  // ---------------------------------------------------------------------
  // Write-back outputs, purely from registered state.
  // ---------------------------------------------------------------------
  logic dest_ok;

  if (R0_HARDWIRED) begin : g_r0_hard
    assign dest_ok = (data_reg[AW-1:0] != '0);
  end else begin : g_r0_soft
    assign dest_ok = 1'b1;
  end

  assign bus.wbData_WB = ctrl_reg.mem2r ? data_reg[DATA_REG_W-1 -: DW]
                                        : data_reg[AW +: DW];
  // Stays asserted while the stage is held; repeated RF writes are harmless.
  assign bus.RegWe_WB  = ctrl_reg.regw & ctrl_reg.valid & dest_ok;

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CW-1:0] retire_cnt_reg;

  // Count valid instructions entering WB on a plain load edge; wraps naturally.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      retire_cnt_reg <= '0;
    end else if (!bus.Flush && !bus.Stall && bus.Valid_MEM) begin
      retire_cnt_reg <= retire_cnt_reg + CW'(1);
    end
  end

  assign RetireCnt = retire_cnt_reg;
`endif

endmodule : mem_wb_stage

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed vector table, multi-cycle
// reset/retire sequences and randomized traffic against a reference model.
// Two instances: R0_HARDWIRED=1 and R0_HARDWIRED=0, driven identically.
module tb_mem_wb_stage;
  import cpu_pipe_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  always #5 Clk = ~Clk;

  mem_wb_stage_if #(.DW(DW), .AW(AW)) bus_r0 ();
  mem_wb_stage_if #(.DW(DW), .AW(AW)) bus_nr0 ();

`ifdef MEMWB_RETIRE_CNT_EN
  logic [CW-1:0] retire_r0;
  logic [CW-1:0] retire_nr0;
`endif

  mem_wb_stage #(.DW(DW), .AW(AW), .R0_HARDWIRED(1'b1), .CW(CW)) dut_r0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_r0)
`ifdef MEMWB_RETIRE_CNT_EN
    ,
    .RetireCnt (retire_r0)
`endif
  );

  mem_wb_stage #(.DW(DW), .AW(AW), .R0_HARDWIRED(1'b0), .CW(CW)) dut_nr0 (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_nr0)
`ifdef MEMWB_RETIRE_CNT_EN
    ,
    .RetireCnt (retire_nr0)
`endif
  );

  typedef struct {
    logic          stall, flush, valid, mem2r, regw;
    logic [DW-1:0] dm, alu;
    logic [AW-1:0] sel;
    logic [DW-1:0] exp_wb;
    logic          exp_we, exp_we_nr0, exp_valid;
    logic [AW-1:0] exp_sel;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Reference model: the instruction currently sitting in WB.
  logic          m_valid, m_mem2r, m_regw;
  logic [DW-1:0] m_dm, m_alu;
  logic [AW-1:0] m_sel;
  int unsigned   m_retired;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, fl, va, m2, rw,
                              input logic [DW-1:0] dm, alu, input logic [AW-1:0] sel,
                              input logic [DW-1:0] ewb, input logic ewe, ewe_nr0, evalid,
                              input logic [AW-1:0] esel);
    vec_t v;
    v.stall = st; v.flush = fl; v.valid = va; v.mem2r = m2; v.regw = rw;
    v.dm = dm; v.alu = alu; v.sel = sel;
    v.exp_wb = ewb; v.exp_we = ewe; v.exp_we_nr0 = ewe_nr0;
    v.exp_valid = evalid; v.exp_sel = esel;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus_r0.Stall = v.stall;        bus_nr0.Stall = v.stall;
    bus_r0.Flush = v.flush;        bus_nr0.Flush = v.flush;
    bus_r0.Valid_MEM = v.valid;    bus_nr0.Valid_MEM = v.valid;
    bus_r0.Mem2R_MEM = v.mem2r;    bus_nr0.Mem2R_MEM = v.mem2r;
    bus_r0.RegW_MEM = v.regw;      bus_nr0.RegW_MEM = v.regw;
    bus_r0.dmDataOut = v.dm;       bus_nr0.dmDataOut = v.dm;
    bus_r0.aluDataOut_MEM = v.alu; bus_nr0.aluDataOut_MEM = v.alu;
    bus_r0.MEM_rfWeSel = v.sel;    bus_nr0.MEM_rfWeSel = v.sel;
  endtask

  function automatic void model_clear();
    m_valid = 0; m_mem2r = 0; m_regw = 0;
    m_dm = '0; m_alu = '0; m_sel = '0; m_retired = 0;
  endfunction

  // One clock edge: flush makes a bubble, stall keeps the instruction,
  // otherwise the MEM instruction moves into WB.
  function automatic void model_edge(input vec_t v);
    if (v.flush) begin
      m_valid = 0; m_mem2r = 0; m_regw = 0;
    end else if (!v.stall) begin
      m_valid = v.valid; m_mem2r = v.mem2r; m_regw = v.regw;
      m_dm = v.dm; m_alu = v.alu; m_sel = v.sel;
      if (v.valid) m_retired++;
    end
  endfunction

  task automatic check_model(input string tag);
    logic [DW-1:0] exp_wb;
    logic exp_we_r0, exp_we_nr0;
    exp_wb     = m_mem2r ? m_dm : m_alu;
    exp_we_nr0 = m_regw && m_valid;
    exp_we_r0  = exp_we_nr0 && (m_sel != 0);
    chk({tag, " valid"}, 64'(bus_r0.Valid_WB), 64'(m_valid));
    chk({tag, " regw"},  64'(bus_r0.RegW_WB),  64'(m_regw));
    chk({tag, " mem2r"}, 64'(bus_r0.Mem2R_WB), 64'(m_mem2r));
    chk({tag, " sel"},   64'(bus_r0.WB_rfWeSel), 64'(m_sel));
    chk({tag, " wbdata"}, 64'(bus_r0.wbData_WB), 64'(exp_wb));
    chk({tag, " we_r0"},  64'(bus_r0.RegWe_WB), 64'(exp_we_r0));
    chk({tag, " we_nr0"}, 64'(bus_nr0.RegWe_WB), 64'(exp_we_nr0));
    chk({tag, " wbdata_nr0"}, 64'(bus_nr0.wbData_WB), 64'(exp_wb));
`ifdef MEMWB_RETIRE_CNT_EN
    chk({tag, " retire"}, 64'(retire_r0), 64'(m_retired % (1 << CW)));
`endif
  endtask

  task automatic check_zero(input string tag);
    chk({tag, " valid"},  64'(bus_r0.Valid_WB), 64'd0);
    chk({tag, " regw"},   64'(bus_r0.RegW_WB), 64'd0);
    chk({tag, " mem2r"},  64'(bus_r0.Mem2R_WB), 64'd0);
    chk({tag, " dm"},     64'(bus_r0.dmDataOut_WB), 64'd0);
    chk({tag, " alu"},    64'(bus_r0.aluDataOut_WB), 64'd0);
    chk({tag, " sel"},    64'(bus_r0.WB_rfWeSel), 64'd0);
    chk({tag, " wbdata"}, 64'(bus_r0.wbData_WB), 64'd0);
    chk({tag, " we_r0"},  64'(bus_r0.RegWe_WB), 64'd0);
    chk({tag, " we_nr0"}, 64'(bus_nr0.RegWe_WB), 64'd0);
`ifdef MEMWB_RETIRE_CNT_EN
    chk({tag, " retire"}, 64'(retire_r0), 64'd0);
`endif
  endtask

  // Drive at (posedge + 1), take the next edge, sample 1 time unit after it.
  task automatic step(input vec_t v);
    drive(v);
    @(posedge Clk);
    model_edge(v);
    #1;
  endtask

  function automatic vec_t rand_vec(input int stall_pct, input int flush_pct);
    vec_t v;
    v = mk(0, 0, 0, 0, 0, '0, '0, '0, '0, 0, 0, 0, '0);
    v.stall = ($urandom_range(0, 99) < stall_pct);
    v.flush = ($urandom_range(0, 99) < flush_pct);
    v.valid = ($urandom_range(0, 99) < 80);
    v.mem2r = $urandom_range(0, 1);
    v.regw  = ($urandom_range(0, 99) < 75);
    v.dm    = $urandom;
    v.alu   = $urandom;
    v.sel   = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom_range(1, (1 << AW) - 1));
    return v;
  endfunction

  // Assert reset between edges with busy inputs; outputs must clear at once.
  task automatic reset_mid_cycle(input string tag);
    vec_t v;
    v = rand_vec(0, 0);
    v.stall = 1; v.flush = $urandom_range(0, 1); v.valid = 1; v.regw = 1;
    drive(v);
    #2 Rst = 1'b1;
    #1 check_zero(tag);
    model_clear();
    #2 Rst = 1'b0;
  endtask

  vec_t table_v[12];
  vec_t v;
  int   pattern[20];

  initial begin
    // Directed table: expected outputs written out by hand.
    table_v[0]  = mk(0,0,1,1,1, 32'hDEADBEEF, 32'h12345678, 5'd7, 32'hDEADBEEF, 1,1,1, 5'd7);
    table_v[1]  = mk(0,0,1,0,1, 32'hDEADBEEF, 32'h12345678, 5'd7, 32'h12345678, 1,1,1, 5'd7);
    table_v[2]  = mk(0,0,1,0,1, 32'h0, 32'hA5, 5'd3, 32'hA5, 1,1,1, 5'd3);
    table_v[3]  = mk(1,0,1,0,1, 32'h0, 32'h5A, 5'd9, 32'hA5, 1,1,1, 5'd3);
    table_v[4]  = mk(1,0,1,0,1, 32'h0, 32'h5A, 5'd9, 32'hA5, 1,1,1, 5'd3);
    table_v[5]  = mk(1,0,1,0,1, 32'h0, 32'h5A, 5'd9, 32'hA5, 1,1,1, 5'd3);
    table_v[6]  = mk(0,0,1,0,1, 32'h0, 32'h5A, 5'd9, 32'h5A, 1,1,1, 5'd9);
    table_v[7]  = mk(1,1,1,1,1, 32'hFFFF0000, 32'h77, 5'd4, 32'h5A, 0,0,0, 5'd9);
    table_v[8]  = mk(0,0,1,0,1, 32'h0, 32'h11, 5'd0, 32'h11, 0,1,1, 5'd0);
    table_v[9]  = mk(0,0,0,0,1, 32'h0, 32'h22, 5'd5, 32'h22, 0,0,0, 5'd5);
    table_v[10] = mk(0,0,1,1,0, 32'hCAFEF00D, 32'h33, 5'd6, 32'hCAFEF00D, 0,0,1, 5'd6);
    table_v[11] = mk(0,1,1,1,1, 32'h1, 32'h2, 5'd8, 32'h33, 0,0,0, 5'd6);

    // Power-on reset with nonzero inputs present.
    model_clear();
    v = rand_vec(0, 0);
    v.valid = 1; v.regw = 1; v.sel = 5'd1;
    drive(v);
    #1 Rst = 1'b1;
    #2 check_zero("por");
    #1 Rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(table_v[i]);
      $display("vec %0d: stall=%0b flush=%0b sel=%0d -> wb=0x%08h we=%0b", i,
               table_v[i].stall, table_v[i].flush, table_v[i].sel,
               bus_r0.wbData_WB, bus_r0.RegWe_WB);
      chk($sformatf("vec%0d wbdata", i), 64'(bus_r0.wbData_WB), 64'(table_v[i].exp_wb));
      chk($sformatf("vec%0d we_r0", i),  64'(bus_r0.RegWe_WB), 64'(table_v[i].exp_we));
      chk($sformatf("vec%0d we_nr0", i), 64'(bus_nr0.RegWe_WB), 64'(table_v[i].exp_we_nr0));
      chk($sformatf("vec%0d valid", i),  64'(bus_r0.Valid_WB), 64'(table_v[i].exp_valid));
      chk($sformatf("vec%0d sel", i),    64'(bus_r0.WB_rfWeSel), 64'(table_v[i].exp_sel));
      check_model($sformatf("vec%0d model", i));
    end

    // Reset in the middle of a stall/flush.
    reset_mid_cycle("rst_mid");
    $display("reset mid-cycle: valid=%0b we=%0b", bus_r0.Valid_WB, bus_r0.RegWe_WB);

    // Retire sequence: 17 valid loads, 2 stalls and 1 flush, from reset.
    for (int i = 0; i < 20; i++) pattern[i] = 0;
    pattern[4] = 1; pattern[9] = 2; pattern[15] = 1;
    for (int i = 0; i < 20; i++) begin
      v = rand_vec(0, 0);
      v.valid = 1;
      v.stall = (pattern[i] == 1);
      v.flush = (pattern[i] == 2);
      step(v);
      $display("retire seq %0d: kind=%0d valid_wb=%0b", i, pattern[i], bus_r0.Valid_WB);
      check_model($sformatf("retire%0d", i));
    end
`ifdef MEMWB_RETIRE_CNT_EN
    chk("retire wrap r0", 64'(retire_r0), 64'd1);
    chk("retire wrap nr0", 64'(retire_nr0), 64'd1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      v = rand_vec(25, 12);
      step(v);
      $display("rand %0d: st=%0b fl=%0b v=%0b sel=%0d -> wb=0x%08h we=%0b/%0b", i,
               v.stall, v.flush, v.valid, v.sel, bus_r0.wbData_WB,
               bus_r0.RegWe_WB, bus_nr0.RegWe_WB);
      check_model($sformatf("rand%0d", i));
      if (i == 150) reset_mid_cycle("rst_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_mem_wb_stage
